// File: rtl/lfsr_unmask.sv
// Streaming 64-bit keystream unmasker: each accepted word is XORed with a Galois LFSR state, then the LFSR steps.
// Optional feature macro: LFSR_UNMASK_BYPASS_EN adds a per-word bypass input that passes data through unmasked.
module lfsr_unmask #(
   parameter int                 WIDTH = 64,
   parameter logic [WIDTH-1:0]   SEED  = 64'h0000_0000_0000_0001,
   parameter logic [WIDTH-1:0]   TAPS  = 64'hD800_0000_0000_0000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             seed_load,
   input  logic [WIDTH-1:0] seed_in,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
`ifdef LFSR_UNMASK_BYPASS_EN
   input  logic             bypass,
`endif
   output logic [31:0]      word_count
);

   typedef enum logic {ST_RUN, ST_RESEED} state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_lfsr;
   logic [WIDTH-1:0] r_outData;
   logic             r_outValid;
   logic [31:0]      r_wordCount;

   logic [WIDTH-1:0] w_lfsrNext;
   logic [WIDTH-1:0] w_seedSafe;
   logic             w_accept;
   logic             w_bypass;

`ifdef LFSR_UNMASK_BYPASS_EN
   assign w_bypass = bypass;
`else
   assign w_bypass = 1'b0;
`endif

   assign w_lfsrNext = (r_lfsr >> 1) ^ (r_lfsr[0] ? TAPS : '0);
   // A zero seed would lock the LFSR at zero forever, so fall back to SEED
   assign w_seedSafe = (seed_in == '0) ? SEED : seed_in;
   assign in_ready   = !seed_load && (!r_outValid || out_ready);
   assign w_accept   = in_valid && in_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= ST_RUN;
         r_lfsr      <= SEED;
         r_outData   <= '0;
         r_outValid  <= 1'b0;
         r_wordCount <= '0;
      end else begin
         case (r_state)
            ST_RUN:    if (seed_load)  r_state <= ST_RESEED;
            ST_RESEED: if (!seed_load) r_state <= ST_RUN;
            default:   r_state <= ST_RUN;
         endcase

         if (seed_load) begin
            r_lfsr      <= w_seedSafe;
            r_wordCount <= '0;
         end else if (w_accept) begin
            if (!w_bypass) begin
               r_lfsr <= w_lfsrNext;
            end
            r_wordCount <= r_wordCount + 32'd1;
         end

         // Output stage refills on accept, otherwise drains when the consumer takes it
         if (w_accept) begin
            r_outData  <= w_bypass ? in_data : (in_data ^ r_lfsr);
            r_outValid <= 1'b1;
         end else if (r_outValid && out_ready) begin
            r_outValid <= 1'b0;
         end
      end
   end

   assign out_valid  = r_outValid;
   assign out_data   = r_outData;
   assign word_count = r_wordCount;

endmodule

// File: tb/tb_lfsr_unmask.sv
// Self-checking bench for lfsr_unmask: keystream-index reference model compared every cycle, plus directed literal checks.
// Build with LFSR_UNMASK_BYPASS_EN defined to also exercise the bypass input.
module tb_lfsr_unmask;

   localparam logic [63:0] SEED = 64'h0000_0000_0000_0001;
   localparam logic [63:0] TAPS = 64'hD800_0000_0000_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        seed_load;
   logic [63:0] seed_in;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_data;
   logic [31:0] word_count;
   logic        bypassIn;

   int total = 0;
   int bad   = 0;
   logic checkEn = 1'b0;

   lfsr_unmask dut (
      .clk        (clk),
      .reset      (reset),
      .seed_load  (seed_load),
      .seed_in    (seed_in),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
`ifdef LFSR_UNMASK_BYPASS_EN
      .bypass     (bypassIn),
`endif
      .word_count (word_count)
   );

   always #5 clk = ~clk;

   // Keystream word n after a given seed: the seed itself stepped n times
   function automatic logic [63:0] ks(input logic [63:0] s0, input int n);
      logic [63:0] s;
      s = s0;
      for (int i = 0; i < n; i++) s = (s >> 1) ^ (s[0] ? TAPS : 64'h0);
      return s;
   endfunction

   // Reference model: tracks which seed is active and how many keystream words it has consumed
   logic [63:0] mSeed;
   int          mIdx;
   logic        mOutValid;
   logic [63:0] mOutData;
   logic [31:0] mCount;
   logic        mAcc;
   logic        mByp;
   logic [63:0] mKs;

`ifdef LFSR_UNMASK_BYPASS_EN
   assign mByp = bypassIn;
`else
   assign mByp = 1'b0;
`endif
   assign mAcc = in_valid && !seed_load && (!mOutValid || out_ready);
   assign mKs  = ks(mSeed, mIdx);

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         mSeed     <= SEED;
         mIdx      <= 0;
         mOutValid <= 1'b0;
         mOutData  <= 64'h0;
         mCount    <= 32'h0;
      end else begin
         if (seed_load) begin
            mSeed  <= (seed_in == 64'h0) ? SEED : seed_in;
            mIdx   <= 0;
            mCount <= 32'h0;
         end
         if (mAcc) begin
            mOutValid <= 1'b1;
            mCount    <= mCount + 32'd1;
            if (mByp) begin
               mOutData <= in_data;
            end else begin
               mOutData <= in_data ^ mKs;
               mIdx     <= mIdx + 1;
            end
         end else if (mOutValid && out_ready) begin
            mOutValid <= 1'b0;
         end
      end
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model, away from the rising edge
   always @(negedge clk) begin
      if (checkEn) begin
         checkOutput("cyc_out_valid",  {63'h0, out_valid}, {63'h0, mOutValid});
         checkOutput("cyc_out_data",   out_data, mOutData);
         checkOutput("cyc_word_count", {32'h0, word_count}, {32'h0, mCount});
         checkOutput("cyc_in_ready",   {63'h0, in_ready},
                     {63'h0, (!seed_load && (!mOutValid || out_ready))});
      end
   end

   task automatic applyStimulus(input logic v, input logic [63:0] d, input logic ordy,
                                input logic sl, input logic [63:0] sin, input logic byp);
      in_valid  = v;
      in_data   = d;
      out_ready = ordy;
      seed_load = sl;
      seed_in   = sin;
      bypassIn  = byp;
      @(posedge clk);
      #2;
   endtask

   logic [63:0] held;
   logic [63:0] rtSeed;
   logic [63:0] p1;
   logic [63:0] p2;

   initial begin
      reset = 1'b1; seed_load = 1'b0; seed_in = 64'h0; in_valid = 1'b0;
      in_data = 64'h0; out_ready = 1'b1; bypassIn = 1'b0;
      @(posedge clk); #2;
      checkOutput("rst_out_valid",  {63'h0, out_valid}, 64'h0);
      checkOutput("rst_out_data",   out_data, 64'h0);
      checkOutput("rst_word_count", {32'h0, word_count}, 64'h0);
      checkOutput("rst_in_ready",   {63'h0, in_ready}, 64'h1);
      reset = 1'b0;
      checkEn = 1'b1;

      // Idle with in_data wiggling: nothing accepted, keystream must not move
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 64'hA5A5_0000_0000_0000 + 64'(i), 1'b1, 1'b0, 64'h0, 1'b0);
      checkOutput("idle_out_valid",  {63'h0, out_valid}, 64'h0);
      checkOutput("idle_word_count", {32'h0, word_count}, 64'h0);

      applyStimulus(1'b1, 64'h0, 1'b1, 1'b0, 64'h0, 1'b0);
      checkOutput("ks0", out_data, 64'h0000_0000_0000_0001);
      applyStimulus(1'b1, 64'h0, 1'b1, 1'b0, 64'h0, 1'b0);
      checkOutput("ks1", out_data, 64'hD800_0000_0000_0000);
      applyStimulus(1'b1, 64'h0, 1'b1, 1'b0, 64'h0, 1'b0);
      checkOutput("ks2", out_data, 64'h6C00_0000_0000_0000);
      checkOutput("ks_count3", {32'h0, word_count}, 64'd3);
      applyStimulus(1'b0, 64'h0, 1'b1, 1'b0, 64'h0, 1'b0);
      checkOutput("drain_valid", {63'h0, out_valid}, 64'h0);

      // Backpressure: one accept, then four stalled cycles with a word waiting
      applyStimulus(1'b1, 64'h0, 1'b0, 1'b0, 64'h0, 1'b0);
      checkOutput("bp_first", out_data, 64'h3600_0000_0000_0000);
      held = out_data;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 64'h0, 1'b0, 1'b0, 64'h0, 1'b0);
         checkOutput("bp_in_ready", {63'h0, in_ready}, 64'h0);
         checkOutput("bp_hold", out_data, held);
      end
      applyStimulus(1'b1, 64'h0, 1'b1, 1'b0, 64'h0, 1'b0);
      checkOutput("bp_release_data",  out_data, 64'h1B00_0000_0000_0000);
      checkOutput("bp_release_count", {32'h0, word_count}, 64'd5);

      // Zero seed load with a word offered: refused, SEED substituted
      in_valid = 1'b1; in_data = 64'h0; out_ready = 1'b1; seed_load = 1'b1; seed_in = 64'h0;
      #1;
      checkOutput("seed_in_ready", {63'h0, in_ready}, 64'h0);
      @(posedge clk); #2;
      checkOutput("seed_count0", {32'h0, word_count}, 64'h0);
      applyStimulus(1'b1, 64'h0, 1'b1, 1'b0, 64'h0, 1'b0);
      checkOutput("seed_zero_sub", out_data, 64'h0000_0000_0000_0001);
      checkOutput("seed_count1",   {32'h0, word_count}, 64'd1);

      // Round trip against a nontrivial seed
      rtSeed = 64'h0123_4567_89AB_CDEF;
      p1 = 64'hDEAD_BEEF_0000_FFFF;
      p2 = 64'hFFFF_FFFF_FFFF_FFFF;
      applyStimulus(1'b0, 64'h0, 1'b1, 1'b1, rtSeed, 1'b0);
      applyStimulus(1'b1, p1 ^ ks(rtSeed, 0), 1'b1, 1'b0, 64'h0, 1'b0);
      checkOutput("rt_p1", out_data, p1);
      applyStimulus(1'b1, p2 ^ ks(rtSeed, 1), 1'b1, 1'b0, 64'h0, 1'b0);
      checkOutput("rt_p2", out_data, p2);

      // Reset mid-stream with a stalled word pending
      applyStimulus(1'b1, 64'h1234, 1'b0, 1'b0, 64'h0, 1'b0);
      reset = 1'b1;
      #1;
      checkOutput("midrst_valid", {63'h0, out_valid}, 64'h0);
      checkOutput("midrst_data",  out_data, 64'h0);
      @(posedge clk); #2;
      reset = 1'b0;
      applyStimulus(1'b1, 64'h0, 1'b1, 1'b0, 64'h0, 1'b0);
      checkOutput("midrst_restart", out_data, SEED);

`ifdef LFSR_UNMASK_BYPASS_EN
      reset = 1'b1;
      @(posedge clk); #2;
      reset = 1'b0;
      applyStimulus(1'b1, 64'h1111_1111_1111_1111, 1'b1, 1'b0, 64'h0, 1'b1);
      checkOutput("byp_pass", out_data, 64'h1111_1111_1111_1111);
      applyStimulus(1'b1, 64'h0, 1'b1, 1'b0, 64'h0, 1'b0);
      checkOutput("byp_then_mask", out_data, SEED);
      checkOutput("byp_count",     {32'h0, word_count}, 64'd2);
`endif

      applyStimulus(1'b0, 64'h0, 1'b1, 1'b0, 64'h0, 1'b0);
      applyStimulus(1'b0, 64'h0, 1'b1, 1'b0, 64'h0, 1'b0);
      checkEn = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
